// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master round-robin arbiter with watchdog for the native memory bus
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_valid,
  output logic                m0_ready,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  output logic                m1_ready,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  input  logic                s_ready,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                fault,
  output logic                fault_master
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_t             state, state_nxt;
  logic               owner, owner_nxt;
  logic               last_grant, last_grant_nxt;
  logic [15:0]        timer, timer_nxt;
  logic               owner_valid;
  logic               grant;
  logic               done;
  logic [DATA_W-1:0]  done_rdata;

  assign owner_valid = owner ? m1_valid : m0_valid;

  // State, ownership and watchdog registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      timer      <= 16'd0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      timer      <= timer_nxt;
    end
  end

  // Sticky record of which master suffered the most recent timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_master <= 1'b0;
    end else if (fault) begin
      fault_master <= owner;
    end
  end

  // Next-state, grant selection, slave mux and completion routing
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    timer_nxt      = timer;
    grant          = 1'b0;
    done           = 1'b0;
    done_rdata     = '0;
    fault          = 1'b0;
    s_valid        = 1'b0;
    s_addr         = '0;
    s_wdata        = '0;
    s_wstrb        = '0;
    m0_ready       = 1'b0;
    m1_ready       = 1'b0;
    m0_rdata       = '0;
    m1_rdata       = '0;

    case (state)
      S_IDLE: begin
        if (m0_valid || m1_valid) begin
          // On a tie the master that did not win last time gets the bus
          grant          = (m0_valid && m1_valid) ? ~last_grant : m1_valid;
          owner_nxt      = grant;
          last_grant_nxt = grant;
          timer_nxt      = 16'd0;
          state_nxt      = S_BUSY;
        end
      end
      S_BUSY: begin
        s_valid = 1'b1;
        s_addr  = owner ? m1_addr  : m0_addr;
        s_wdata = owner ? m1_wdata : m0_wdata;
        s_wstrb = owner ? m1_wstrb : m0_wstrb;
        if (!owner_valid) begin
          // Owner abandoned the request: end it quietly
          state_nxt = S_RELEASE;
        end else if (s_ready) begin
          // A real response beats a coincident timeout
          done       = 1'b1;
          done_rdata = s_rdata;
          state_nxt  = S_RELEASE;
        end else if (timer == TIMER_LAST) begin
          done      = 1'b1;
          fault     = 1'b1;
          state_nxt = S_RELEASE;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end
      S_RELEASE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (done) begin
      if (owner) begin
        m1_ready = 1'b1;
        m1_rdata = done_rdata;
      end else begin
        m0_ready = 1'b1;
        m0_rdata = done_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m1_valid, s_ready;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;

  logic        m0_ready, m1_ready, s_valid, fault, fault_master;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0]  s_wstrb;

  logic        b_m0_ready, b_m1_ready, b_s_valid, b_fault, b_fault_master;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
  logic [3:0]  b_s_wstrb;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cyc_start;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .fault(fault), .fault_master(fault_master)
  );

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(b_m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(b_m0_rdata),
    .m1_valid(m1_valid), .m1_ready(b_m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(b_m1_rdata),
    .s_valid(b_s_valid), .s_ready(s_ready), .s_addr(b_s_addr), .s_wdata(b_s_wdata),
    .s_wstrb(b_s_wstrb), .s_rdata(s_rdata),
    .fault(b_fault), .fault_master(b_fault_master)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=%0d expected=finish", cyc);
    $fatal(1, "bench timed out");
  end

  initial begin
    rst = 1'b0;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready = 1'b0; s_rdata = '0;
    step();

    // Reset state
    do_reset();
    check("rst_s_valid", {31'd0, s_valid}, 32'd0);
    check("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
    check("rst_m1_ready", {31'd0, m1_ready}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_fault_master", {31'd0, fault_master}, 32'd0);
    check("rst_m0_rdata", m0_rdata, 32'd0);

    // Single read, slave answers on the 2nd BUSY cycle
    m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0;
    #1;
    check("rd_svalid_idle", {31'd0, s_valid}, 32'd0);
    step();
    check("rd_svalid_busy", {31'd0, s_valid}, 32'd1);
    check("rd_saddr", s_addr, 32'h100);
    check("rd_swstrb", {28'd0, s_wstrb}, 32'd0);
    check("rd_no_ready_early", {31'd0, m0_ready}, 32'd0);
    step();
    s_ready = 1'b1; s_rdata = 32'hDEADBEEF;
    #1;
    check("rd_m0_ready", {31'd0, m0_ready}, 32'd1);
    check("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    check("rd_m1_ready", {31'd0, m1_ready}, 32'd0);
    step();
    s_ready = 1'b0; m0_valid = 1'b0;
    #1;
    check("rd_release_svalid", {31'd0, s_valid}, 32'd0);
    check("rd_release_ready", {31'd0, m0_ready}, 32'd0);
    step();

    // Contention straight after reset: m0 wins first
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h10; m0_wdata = 32'h11223344; m0_wstrb = 4'hF;
    m1_valid = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h0; m1_wstrb = 4'h0;
    step();
    check("ct_saddr0", s_addr, 32'h10);
    check("ct_swdata0", s_wdata, 32'h11223344);
    check("ct_swstrb0", {28'd0, s_wstrb}, 32'hF);
    check("ct_m1_ready_idle", {31'd0, m1_ready}, 32'd0);
    s_ready = 1'b1; s_rdata = 32'h0;
    #1;
    check("ct_m0_ready", {31'd0, m0_ready}, 32'd1);
    check("ct_m1_not_ready", {31'd0, m1_ready}, 32'd0);
    step();
    s_ready = 1'b0; m0_valid = 1'b0;
    #1;
    check("ct_release", {31'd0, s_valid}, 32'd0);
    step();
    step();
    check("ct_saddr1", s_addr, 32'h20);
    check("ct_swstrb1", {28'd0, s_wstrb}, 32'd0);
    s_ready = 1'b1; s_rdata = 32'h000055AA;
    #1;
    check("ct_m1_ready", {31'd0, m1_ready}, 32'd1);
    check("ct_m1_rdata", m1_rdata, 32'h000055AA);
    check("ct_m0_idle", {31'd0, m0_ready}, 32'd0);
    step();
    s_ready = 1'b0; m1_valid = 1'b0;
    step();

    // Round robin, both masters always requesting, slave answers on 2nd BUSY cycle
    m0_valid = 1'b1; m0_addr = 32'hA0; m0_wstrb = 4'h0;
    m1_valid = 1'b1; m1_addr = 32'hB0; m1_wstrb = 4'h0;
    cyc_start = cyc;
    for (int k = 0; k < 6; k++) begin
      step();
      step();
      s_ready = 1'b1; s_rdata = 32'h100 + k;
      #1;
      check($sformatf("rr_saddr_%0d", k), s_addr, (k % 2 == 0) ? 32'hA0 : 32'hB0);
      check($sformatf("rr_m0_ready_%0d", k), {31'd0, m0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr_m1_ready_%0d", k), {31'd0, m1_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
      step();
      s_ready = 1'b0;
      step();
    end
    check("rr_cycles", cyc - cyc_start, 32'd24);
    m0_valid = 1'b0; m1_valid = 1'b0;

    // Watchdog: slave never answers m1, TIMEOUT=8
    m1_valid = 1'b1; m1_addr = 32'h200; m1_wstrb = 4'h0; s_rdata = 32'hFFFFFFFF;
    step();
    for (int i = 0; i < 7; i++) begin
      check($sformatf("to_wait_ready_%0d", i), {31'd0, m1_ready}, 32'd0);
      check($sformatf("to_wait_fault_%0d", i), {31'd0, fault}, 32'd0);
      step();
    end
    check("to_s_valid", {31'd0, s_valid}, 32'd1);
    check("to_m1_ready", {31'd0, m1_ready}, 32'd1);
    check("to_m1_rdata", m1_rdata, 32'd0);
    check("to_fault", {31'd0, fault}, 32'd1);
    step();
    m1_valid = 1'b0;
    #1;
    check("to_fault_pulse", {31'd0, fault}, 32'd0);
    check("to_fault_master", {31'd0, fault_master}, 32'd1);
    check("to_release", {31'd0, s_valid}, 32'd0);
    step();
    m0_valid = 1'b1; m0_addr = 32'h300;
    step();
    check("to_next_saddr", s_addr, 32'h300);
    s_ready = 1'b1; s_rdata = 32'h1234;
    #1;
    check("to_next_m0_ready", {31'd0, m0_ready}, 32'd1);
    check("to_next_m0_rdata", m0_rdata, 32'h1234);
    check("to_next_no_fault", {31'd0, fault}, 32'd0);
    step();
    s_ready = 1'b0; m0_valid = 1'b0;
    step();

    // Reset in the middle of an m0 transfer restores m0 priority
    m0_valid = 1'b1; m0_addr = 32'h500;
    step();
    check("mr_busy", {31'd0, s_valid}, 32'd1);
    rst = 1'b1; s_ready = 1'b1;
    step();
    rst = 1'b0; s_ready = 1'b0;
    m1_valid = 1'b1; m1_addr = 32'h600;
    #1;
    check("mr_s_valid", {31'd0, s_valid}, 32'd0);
    check("mr_no_ready", {31'd0, m0_ready}, 32'd0);
    check("mr_fault_master", {31'd0, fault_master}, 32'd0);
    step();
    check("mr_tie_m0", s_addr, 32'h500);
    s_ready = 1'b1; s_rdata = 32'h77;
    #1;
    check("mr_m0_ready", {31'd0, m0_ready}, 32'd1);
    step();
    s_ready = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0;
    step();

    // TIMEOUT=4 instance: response arrives on the timeout cycle
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h400; m0_wstrb = 4'h0; s_rdata = 32'h0;
    step();
    step();
    step();
    step();
    #1;
    check("co_fault_armed", {31'd0, b_fault}, 32'd1);
    s_ready = 1'b1; s_rdata = 32'hCAFEF00D;
    #1;
    check("co_m0_ready", {31'd0, b_m0_ready}, 32'd1);
    check("co_m0_rdata", b_m0_rdata, 32'hCAFEF00D);
    check("co_no_fault", {31'd0, b_fault}, 32'd0);
    step();
    s_ready = 1'b0; m0_valid = 1'b0;
    #1;
    check("co_release", {31'd0, b_s_valid}, 32'd0);
    check("co_fault_master", {31'd0, b_fault_master}, 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
